// File: rtl/dram_stream_reader_pkg.sv
// Shared definitions for the DRAM stream reader: controller state encoding.
package dram_stream_reader_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    LOAD  = 2'd1,
    FETCH = 2'd2,
    DRAIN = 2'd3
  } state_t;

endpackage

// File: rtl/dram_stream_reader_sync_fifo.sv
// Prefetch FIFO: registered storage with a combinational head read.
// A push into a full FIFO is dropped even if a pop happens in the same cycle;
// flush empties the FIFO and wins over a concurrent push or pop.
module sync_fifo #(
  parameter int DATA_WIDTH = 32,
  parameter int FIFO_DEPTH = 4
) (
  input  logic                          clk,
  input  logic                          reset,
  input  logic                          flush,
  input  logic                          push,
  input  logic [DATA_WIDTH-1:0]         wData,
  input  logic                          pop,
  output logic [DATA_WIDTH-1:0]         rData,
  output logic [$clog2(FIFO_DEPTH):0]   count
);

  localparam int PW = $clog2(FIFO_DEPTH);
  localparam int CW = PW + 1;

  logic [DATA_WIDTH-1:0] mem [FIFO_DEPTH];
  logic [PW-1:0]         wrPtr;
  logic [PW-1:0]         rdPtr;
  logic                  pushOk;
  logic                  popOk;

  assign pushOk = push & (count != CW'(FIFO_DEPTH)) & ~flush;
  assign popOk  = pop  & (count != '0) & ~flush;
  assign rData  = mem[rdPtr];

  // Storage write; contents need no reset because count gates visibility.
  always_ff @(posedge clk) begin
    if (pushOk) mem[wrPtr] <= wData;
  end

  // Pointers wrap naturally at the power-of-two depth; count tracks occupancy.
  always_ff @(posedge clk) begin
    if (reset || flush) begin
      wrPtr <= '0;
      rdPtr <= '0;
      count <= '0;
    end else begin
      if (pushOk) wrPtr <= wrPtr + PW'(1);
      if (popOk)  rdPtr <= rdPtr + PW'(1);
      case ({pushOk, popOk})
        2'b10:   count <= count + CW'(1);
        2'b01:   count <= count - CW'(1);
        default: count <= count;
      endcase
    end
  end

endmodule

// File: rtl/dram_stream_reader.sv
// Streams a block of DRAM words from the arbiter auxiliary read port into a
// prefetch FIFO. Arbiter side: auxRReady marks a prefetched word, auxRDataAck
// consumes it in the same cycle. Stream side is valid/ready: a word transfers
// on every cycle where streamValid and streamReady are both high; streamData
// is stable while streamValid is high and streamReady is low.
module dram_stream_reader
  import dram_stream_reader_pkg::*;
#(
  parameter int ADDR_WIDTH = 32,
  parameter int DATA_WIDTH = 32,
  parameter int LEN_WIDTH  = 16,
  parameter int FIFO_DEPTH = 4
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  start,
  input  logic                  abort,
  input  logic [ADDR_WIDTH-1:0] startAddr,
  input  logic [LEN_WIDTH-1:0]  length,
  output logic                  busy,
  output logic                  done,
  output logic                  auxRAddrWrite,
  output logic [ADDR_WIDTH-1:0] auxRAddrWData,
  output logic                  auxRDataAck,
  input  logic                  auxRReady,
  input  logic [DATA_WIDTH-1:0] auxRData,
  output logic                  streamValid,
  input  logic                  streamReady,
  output logic [DATA_WIDTH-1:0] streamData
);

  localparam int CW = $clog2(FIFO_DEPTH) + 1;

  state_t                state;
  state_t                stateNext;
  logic                  doneNext;
  logic [LEN_WIDTH-1:0]  remaining;
  logic [ADDR_WIDTH-1:0] addrReg;
  logic [CW-1:0]         fifoCount;
  logic                  push;
  logic                  pop;
  logic                  accept;

  // A start is taken only in IDLE and only when no abort competes with it.
  assign accept = (state == IDLE) & start & ~abort;

  // Push needs a ready word, FIFO room and words left to fetch; the arbiter
  // drops auxRReady on the edge that registers the ack, so no guard cycle.
  assign push = (state == FETCH) & auxRReady & (fifoCount < CW'(FIFO_DEPTH))
              & (remaining != '0) & ~abort & ~reset;
  assign pop  = streamValid & streamReady;

  assign auxRDataAck   = push;
  assign auxRAddrWrite = (state == LOAD) & ~abort & ~reset;
  assign auxRAddrWData = addrReg;
  assign busy          = (state != IDLE);
  assign streamValid   = (fifoCount != '0);

  sync_fifo #(
    .DATA_WIDTH (DATA_WIDTH),
    .FIFO_DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk   (clk),
    .reset (reset),
    .flush (abort),
    .push  (push),
    .wData (auxRData),
    .pop   (pop),
    .rData (streamData),
    .count (fifoCount)
  );

  // Next-state and done decision; abort overrides every transition.
  always_comb begin
    stateNext = state;
    doneNext  = 1'b0;
    case (state)
      IDLE: begin
        if (accept) begin
          if (length != '0) stateNext = LOAD;
          else              doneNext  = 1'b1;
        end
      end
      LOAD:  stateNext = FETCH;
      FETCH: begin
        if (remaining == '0 || (push && remaining == LEN_WIDTH'(1))) stateNext = DRAIN;
      end
      DRAIN: begin
        if (fifoCount == '0) begin
          stateNext = IDLE;
          doneNext  = 1'b1;
        end
      end
      default: stateNext = IDLE;
    endcase
    if (abort) begin
      stateNext = IDLE;
      doneNext  = 1'b0;
    end
  end

  // State, done pulse, latched address and remaining-word counter.
  always_ff @(posedge clk) begin
    if (reset) begin
      state     <= IDLE;
      done      <= 1'b0;
      remaining <= '0;
      addrReg   <= '0;
    end else begin
      state <= stateNext;
      done  <= doneNext;
      if (abort) begin
        remaining <= '0;
      end else if (accept && length != '0) begin
        remaining <= length;
        addrReg   <= startAddr;
      end else if (push) begin
        remaining <= remaining - LEN_WIDTH'(1);
      end
    end
  end

endmodule

// File: tb/tb_dram_stream_reader.sv
// Directed bench for dram_stream_reader with a behavioural arbiter model.
module tb_dram_stream_reader;

  localparam int AW = 32;
  localparam int DW = 32;
  localparam int LW = 16;
  localparam int FD = 4;

  logic          clk = 1'b0;
  logic          reset;
  logic          start;
  logic          abort;
  logic [AW-1:0] startAddr;
  logic [LW-1:0] length;
  logic          busy;
  logic          done;
  logic          auxRAddrWrite;
  logic [AW-1:0] auxRAddrWData;
  logic          auxRDataAck;
  logic          auxRReady;
  logic [DW-1:0] auxRData;
  logic          streamValid;
  logic          streamReady;
  logic [DW-1:0] streamData;

  int checks = 0;
  int errors = 0;
  logic [DW-1:0] exp_q[$];

  int            awCount;
  int            ackCount;
  int            doneCount;
  int            busyCount;
  logic [AW-1:0] lastAw;

  logic [AW-1:0] arbAddr;
  int            arbDelay;

  function automatic logic [DW-1:0] word_at(input logic [AW-1:0] a);
    return a ^ 32'h5A00_0000;
  endfunction

  // clock/reset
  always #5 clk = ~clk;

  dram_stream_reader #(
    .ADDR_WIDTH (AW),
    .DATA_WIDTH (DW),
    .LEN_WIDTH  (LW),
    .FIFO_DEPTH (FD)
  ) dut (
    .clk           (clk),
    .reset         (reset),
    .start         (start),
    .abort         (abort),
    .startAddr     (startAddr),
    .length        (length),
    .busy          (busy),
    .done          (done),
    .auxRAddrWrite (auxRAddrWrite),
    .auxRAddrWData (auxRAddrWData),
    .auxRDataAck   (auxRDataAck),
    .auxRReady     (auxRReady),
    .auxRData      (auxRData),
    .streamValid   (streamValid),
    .streamReady   (streamReady),
    .streamData    (streamData)
  );

  // Arbiter model: word ready a couple of cycles after each address load or ack.
  assign auxRData = word_at(arbAddr);
  always @(posedge clk) begin
    if (reset) begin
      auxRReady <= 1'b0;
      arbDelay  <= 0;
      arbAddr   <= '0;
    end else if (auxRAddrWrite) begin
      arbAddr   <= auxRAddrWData;
      auxRReady <= 1'b0;
      arbDelay  <= 2;
    end else if (auxRDataAck) begin
      arbAddr   <= arbAddr + 1;
      auxRReady <= 1'b0;
      arbDelay  <= 2;
    end else if (arbDelay > 1) begin
      arbDelay <= arbDelay - 1;
    end else if (arbDelay == 1) begin
      arbDelay  <= 0;
      auxRReady <= 1'b1;
    end
  end

  // Scoreboard and event counters, sampled mid-cycle.
  always @(negedge clk) begin
    if (!reset) begin
      if (auxRAddrWrite) begin
        awCount++;
        lastAw = auxRAddrWData;
      end
      if (auxRDataAck) ackCount++;
      if (done) doneCount++;
      if (busy) busyCount++;
      if (streamValid && streamReady) begin
        checks++;
        if (exp_q.size() == 0) begin
          errors++;
          $display("FAIL stream_extra: got %h, required no word", streamData);
        end else begin
          logic [DW-1:0] e;
          e = exp_q.pop_front();
          if (streamData !== e) begin
            errors++;
            $display("FAIL stream_word: got %h, required %h", streamData, e);
          end
        end
      end
    end
  end

  // driver tasks
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic clear_counts();
    awCount = 0; ackCount = 0; doneCount = 0; busyCount = 0; lastAw = '0;
  endtask

  task automatic pulse_start(input logic [AW-1:0] a, input logic [LW-1:0] l);
    start = 1'b1; startAddr = a; length = l;
    tick();
    start = 1'b0;
  endtask

  task automatic expect_words(input logic [AW-1:0] a, input int n);
    for (int i = 0; i < n; i++) exp_q.push_back(word_at(a + AW'(i)));
  endtask

  task automatic wait_idle(input int budget, output bit ok);
    ok = 1'b0;
    for (int i = 0; i < budget; i++) begin
      if (!busy) begin
        ok = 1'b1;
        break;
      end
      tick();
    end
    tick();
    tick();
  endtask

  task automatic wait_acks(input int n, input int budget, output bit ok);
    ok = 1'b0;
    for (int i = 0; i < budget; i++) begin
      if (ackCount >= n) begin
        ok = 1'b1;
        break;
      end
      tick();
    end
  endtask

  task automatic test_reset();
    reset = 1'b1; start = 1'b0; abort = 1'b0; startAddr = '0; length = '0; streamReady = 1'b0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL reset_busy: got %b, required 0", busy); end
    checks++; if (done !== 1'b0) begin errors++; $display("FAIL reset_done: got %b, required 0", done); end
    checks++; if (auxRAddrWrite !== 1'b0) begin errors++; $display("FAIL reset_aw: got %b, required 0", auxRAddrWrite); end
    checks++; if (auxRDataAck !== 1'b0) begin errors++; $display("FAIL reset_ack: got %b, required 0", auxRDataAck); end
    checks++; if (streamValid !== 1'b0) begin errors++; $display("FAIL reset_valid: got %b, required 0", streamValid); end
    tick();
    reset = 1'b0;
    tick();
  endtask

  task automatic test_basic();
    bit ok;
    clear_counts();
    streamReady = 1'b1;
    expect_words(32'h100, 3);
    pulse_start(32'h100, 3);
    wait_idle(200, ok);
    checks++; if (!ok) begin errors++; $display("FAIL basic_timeout: got busy, required idle"); end
    checks++; if (awCount != 1) begin errors++; $display("FAIL basic_aw_count: got %0d, required 1", awCount); end
    checks++; if (lastAw !== 32'h100) begin errors++; $display("FAIL basic_aw_addr: got %h, required 100", lastAw); end
    checks++; if (ackCount != 3) begin errors++; $display("FAIL basic_acks: got %0d, required 3", ackCount); end
    checks++; if (doneCount != 1) begin errors++; $display("FAIL basic_done: got %0d, required 1", doneCount); end
    checks++; if (exp_q.size() != 0) begin errors++; $display("FAIL basic_words_left: got %0d, required 0", exp_q.size()); end
  endtask

  task automatic test_backpressure();
    bit ok;
    clear_counts();
    streamReady = 1'b0;
    expect_words(32'h40, 8);
    pulse_start(32'h40, 8);
    repeat (20) tick();
    checks++; if (ackCount != 4) begin errors++; $display("FAIL bp_acks_full: got %0d, required 4", ackCount); end
    checks++; if (streamValid !== 1'b1) begin errors++; $display("FAIL bp_valid: got %b, required 1", streamValid); end
    // FIFO full, arbiter word waiting, consumer now ready: pop only.
    streamReady = 1'b1;
    #1;
    checks++; if (auxRDataAck !== 1'b0) begin errors++; $display("FAIL full_push_blocked: got ack %b, required 0", auxRDataAck); end
    tick();
    checks++; if (auxRDataAck !== 1'b1) begin errors++; $display("FAIL full_push_deferred: got ack %b, required 1", auxRDataAck); end
    wait_idle(300, ok);
    checks++; if (!ok) begin errors++; $display("FAIL bp_timeout: got busy, required idle"); end
    checks++; if (ackCount != 8) begin errors++; $display("FAIL bp_acks_total: got %0d, required 8", ackCount); end
    checks++; if (doneCount != 1) begin errors++; $display("FAIL bp_done: got %0d, required 1", doneCount); end
    checks++; if (exp_q.size() != 0) begin errors++; $display("FAIL bp_words_left: got %0d, required 0", exp_q.size()); end
  endtask

  task automatic test_zero_len();
    clear_counts();
    streamReady = 1'b1;
    pulse_start(32'h80, 0);
    checks++; if (done !== 1'b1) begin errors++; $display("FAIL zero_done_pulse: got %b, required 1", done); end
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL zero_busy: got %b, required 0", busy); end
    tick();
    checks++; if (done !== 1'b0) begin errors++; $display("FAIL zero_done_width: got %b, required 0", done); end
    repeat (5) tick();
    checks++; if (awCount != 0) begin errors++; $display("FAIL zero_aw: got %0d, required 0", awCount); end
    checks++; if (ackCount != 0) begin errors++; $display("FAIL zero_ack: got %0d, required 0", ackCount); end
    checks++; if (busyCount != 0) begin errors++; $display("FAIL zero_busy_seen: got %0d, required 0", busyCount); end
    checks++; if (doneCount != 1) begin errors++; $display("FAIL zero_done_count: got %0d, required 1", doneCount); end
  endtask

  task automatic test_abort();
    bit ok;
    clear_counts();
    streamReady = 1'b1;
    expect_words(32'h600, 6);
    pulse_start(32'h600, 6);
    wait_acks(2, 200, ok);
    checks++; if (!ok) begin errors++; $display("FAIL abort_wait_acks: got %0d, required 2", ackCount); end
    abort = 1'b1;
    tick();
    abort = 1'b0;
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL abort_busy: got %b, required 0", busy); end
    checks++; if (streamValid !== 1'b0) begin errors++; $display("FAIL abort_valid: got %b, required 0", streamValid); end
    exp_q.delete();
    repeat (6) tick();
    checks++; if (doneCount != 0) begin errors++; $display("FAIL abort_no_done: got %0d, required 0", doneCount); end
    checks++; if (ackCount != 2) begin errors++; $display("FAIL abort_acks: got %0d, required 2", ackCount); end
    expect_words(32'h200, 1);
    pulse_start(32'h200, 1);
    wait_idle(200, ok);
    checks++; if (!ok) begin errors++; $display("FAIL restart_timeout: got busy, required idle"); end
    checks++; if (lastAw !== 32'h200) begin errors++; $display("FAIL restart_addr: got %h, required 200", lastAw); end
    checks++; if (ackCount != 3) begin errors++; $display("FAIL restart_acks: got %0d, required 3", ackCount); end
    checks++; if (doneCount != 1) begin errors++; $display("FAIL restart_done: got %0d, required 1", doneCount); end
    checks++; if (exp_q.size() != 0) begin errors++; $display("FAIL restart_words_left: got %0d, required 0", exp_q.size()); end
  endtask

  task automatic test_start_while_busy();
    bit ok;
    clear_counts();
    streamReady = 1'b1;
    expect_words(32'h300, 4);
    pulse_start(32'h300, 4);
    tick();
    tick();
    pulse_start(32'h400, 2);
    wait_idle(300, ok);
    checks++; if (!ok) begin errors++; $display("FAIL busy_start_timeout: got busy, required idle"); end
    checks++; if (awCount != 1) begin errors++; $display("FAIL busy_start_aw: got %0d, required 1", awCount); end
    checks++; if (ackCount != 4) begin errors++; $display("FAIL busy_start_acks: got %0d, required 4", ackCount); end
    checks++; if (doneCount != 1) begin errors++; $display("FAIL busy_start_done: got %0d, required 1", doneCount); end
    checks++; if (exp_q.size() != 0) begin errors++; $display("FAIL busy_start_words_left: got %0d, required 0", exp_q.size()); end
  endtask

  task automatic test_reset_in_drain();
    bit ok;
    clear_counts();
    streamReady = 1'b0;
    expect_words(32'h500, 4);
    pulse_start(32'h500, 4);
    wait_acks(4, 200, ok);
    checks++; if (!ok) begin errors++; $display("FAIL drain_wait_acks: got %0d, required 4", ackCount); end
    tick();
    reset = 1'b1;
    tick();
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL drain_reset_busy: got %b, required 0", busy); end
    checks++; if (done !== 1'b0) begin errors++; $display("FAIL drain_reset_done: got %b, required 0", done); end
    checks++; if (auxRAddrWrite !== 1'b0) begin errors++; $display("FAIL drain_reset_aw: got %b, required 0", auxRAddrWrite); end
    checks++; if (auxRDataAck !== 1'b0) begin errors++; $display("FAIL drain_reset_ack: got %b, required 0", auxRDataAck); end
    checks++; if (streamValid !== 1'b0) begin errors++; $display("FAIL drain_reset_valid: got %b, required 0", streamValid); end
    reset = 1'b0;
    exp_q.delete();
    streamReady = 1'b1;
    repeat (6) tick();
    checks++; if (doneCount != 0) begin errors++; $display("FAIL drain_reset_no_done: got %0d, required 0", doneCount); end
  endtask

  // Watchdog so the run always ends.
  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached, required completion");
    $fatal(1, "watchdog");
  end

  initial begin
    clear_counts();
    test_reset();
    test_basic();
    test_backpressure();
    test_zero_len();
    test_abort();
    test_start_while_busy();
    test_reset_in_drain();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/dram_stream_reader.md
DRAM_STREAM_READER -- requirements
Module: dram_stream_reader

Interface
REQ-001 Parameter ADDR_WIDTH, default 32, SHALL set the DRAM word address width; it matches the arbiter auxiliary port width.
REQ-002 Parameter DATA_WIDTH, default 32, SHALL set the word width.
REQ-003 Parameter LEN_WIDTH, default 16, SHALL set the transfer-length counter width.
REQ-004 Parameter FIFO_DEPTH, default 4, power of two >= 2, SHALL set the prefetch FIFO depth.
REQ-005 Ports SHALL be (name  direction  width  meaning):
- clk  in  1  single clock, all logic rising-edge.
- reset  in  1  synchronous, active-high.
- start  in  1  one-cycle request that latches startAddr and length.
- abort  in  1  cancels the transfer and flushes the FIFO.
- startAddr  in  ADDR_WIDTH  first word address.
- length  in  LEN_WIDTH  word count; 0 is legal.
- busy  out  1  high from the start acceptance until IDLE.
- done  out  1  one-cycle pulse at normal completion.
- auxRAddrWrite  out  1  drives the arbiter aux address H and L loads together.
- auxRAddrWData  out  ADDR_WIDTH  address to load.
- auxRDataAck  out  1  consumes the arbiter prefetched word.
- auxRReady  in  1  arbiter prefetched word valid.
- auxRData  in  DATA_WIDTH  arbiter prefetched word.
- streamValid  out  1  FIFO head valid.
- streamReady  in  1  consumer accepts the head.
- streamData  out  DATA_WIDTH  FIFO head word.

Function
REQ-006 The state machine SHALL have states IDLE, LOAD, FETCH and DRAIN.
REQ-007 IDLE SHALL accept start: with length!=0 go to LOAD; with length==0 stay IDLE and pulse done next cycle, with no arbiter access.
REQ-008 LOAD SHALL assert auxRAddrWrite for exactly 1 cycle with auxRAddrWData=startAddr, then go to FETCH.
REQ-009 FETCH push condition SHALL be auxRReady & (fifoCount<FIFO_DEPTH) & (remaining!=0), using values sampled at the start of the cycle.
REQ-010 On push, in the same cycle, the block SHALL assert auxRDataAck, write auxRData into the FIFO, and decrement remaining by 1.
REQ-011 The block SHALL NOT assert auxRDataAck without a push.
REQ-012 The block SHALL rely on the arbiter clearing auxRReady on the edge that registers ack or address write; no extra guard cycle is needed.
REQ-013 FETCH SHALL go to DRAIN when remaining reaches 0.
REQ-014 DRAIN SHALL go to IDLE when the FIFO is empty, pulsing done for 1 cycle on that transition.
REQ-015 streamValid SHALL equal (fifoCount!=0).
REQ-016 streamData SHALL be the FIFO head, registered storage, combinational read.
REQ-017 A pop SHALL occur when streamValid & streamReady.
REQ-018 Simultaneous push and pop SHALL be legal: count unchanged, order preserved.
REQ-019 With the FIFO full, a push SHALL be blocked even if a pop occurs in the same cycle.
REQ-020 FIFO pointers SHALL wrap modulo FIFO_DEPTH.
REQ-021 fifoCount SHALL be $clog2(FIFO_DEPTH)+1 bits wide.
REQ-022 Latency: start at cycle 0 -> auxRAddrWrite in cycle 1 -> earliest push in cycle 2 -> earliest streamValid in cycle 3.
REQ-023 start while busy SHALL be ignored.
REQ-024 When start and abort are both high in IDLE, abort SHALL win and start SHALL be ignored.
REQ-025 abort in any state SHALL, at the next edge:
- enter IDLE;
- clear FIFO and remaining;
- suppress that cycle's push and ack;
- produce no done pulse.
REQ-026 An arbiter read already in flight at abort time SHALL be left pending; the next start reloads the address, invalidating it.
REQ-027 busy SHALL be (state!=IDLE).

Reset
REQ-028 While reset is high, state SHALL be IDLE and FIFO pointers, fifoCount and remaining SHALL be 0.
REQ-029 While reset is high, outputs SHALL be: busy=0, done=0, auxRAddrWrite=0, auxRDataAck=0, streamValid=0.
REQ-030 auxRAddrWData and streamData SHALL be don't-care while reset is high.
REQ-031 Reset mid-transfer SHALL behave like abort, with no done pulse.
REQ-032 Reset SHALL take priority over start and abort.

Structure
REQ-033 A shared package SHALL hold the state encoding constants (IDLE=0, LOAD=1, FETCH=2, DRAIN=3).
REQ-034 The FIFO SHALL be one sub-module, sync_fifo, parameterised by DATA_WIDTH and FIFO_DEPTH, with a flush input.
REQ-035 The control FSM and the remaining counter SHALL reside in dram_stream_reader.

Verification
REQ-036 start, addr=0x100, len=3; arbiter model ready 2 cycles after each ack/load; streamReady=1 -> one auxRAddrWrite with 0x100, 3 acks, stream words D0..D2 in order, done pulse once.
REQ-037 len=8, FIFO_DEPTH=4, streamReady=0 for 20 cycles -> exactly 4 acks, then none, streamValid=1; after streamReady=1, all 8 words delivered in order.
REQ-038 start, len=0 -> no auxRAddrWrite, no ack, done high 1 cycle later, busy never high.
REQ-039 abort after 2 of 6 words -> busy=0 next cycle, streamValid=0, no done; a new start, addr=0x200, len=1, delivers the word at 0x200 only.
REQ-040 FIFO full with streamReady=1 and auxRReady=1 in the same cycle -> pop occurs, push deferred one cycle, no word lost or duplicated.
REQ-041 Second start pulse during FETCH -> ignored, transfer and word count unchanged; reset asserted mid-DRAIN -> all outputs at reset values next cycle.
